clock_display_scan: RTL
=======================

// Module: clock_display_scan
// PURPOSE
//  Downstream of the 12-hour clock core. Takes its binary hh/mm/ss/pm outputs and drives a
//  6-digit multiplexed 7-segment display (HH:MM:SS), one digit at a time.
//  Snapshots the time once per scan frame so a displayed frame never mixes two clock states.
//  Converts each field to BCD, blanks the leading hour zero and marks PM on the decimal point.
// PARAMETERS
//  SCAN_DIV        1000  clk cycles per digit slot; legal range 4..65535
//  BLANK           2     cycles at the start of each slot with all anodes off (anti-ghost); BLANK < SCAN_DIV
//  SEG_ACTIVE_LOW  1     1: seg/dp are driven low = lit; 0: high = lit
//  AN_ACTIVE_LOW   1     1: an bit is driven low = digit enabled; 0: high = enabled
// PORTS
//  clk          in   1  system clock
//  reset        in   1  asynchronous, active-low reset
//  hh           in   8  hours, binary; valid range 1..12
//  mm           in   8  minutes, binary; valid range 0..59
//  ss           in   8  seconds, binary; valid range 0..59
//  pm           in   1  1 = PM
//  seg          out  7  segments {g,f,e,d,c,b,a}; polarity set by SEG_ACTIVE_LOW
//  dp           out  1  decimal point; polarity set by SEG_ACTIVE_LOW
//  an           out  6  one-hot digit enable; an[0]=ss ones ... an[5]=hh tens
//  frame_start  out  1  1-cycle pulse, high while slot 0 of a new frame begins
// BEHAVIOUR
//  - Clocking and reset: one clock; reset is asynchronous and active-low.
//  - Reset values (immediate, no clock needed):
//    - cnt = 0, dig = 0, shadow = 0, load_pend = 1.
//    - an all disabled; seg and dp unlit; frame_start = 0.
//  - cnt: counts 0..SCAN_DIV-1 every cycle.
//    - When cnt == SCAN_DIV-1: cnt <= 0 and dig <= (dig == 5) ? 0 : dig + 1.
//  - Snapshot: shadow <= {hh, mm, ss, pm} when either condition holds:
//    - (cnt == SCAN_DIV-1 && dig == 5), or
//    - load_pend == 1. This is the first clock after reset release; load_pend then clears.
//    - frame_start <= 1 on those same edges, else 0.
//    - Inputs are ignored at all other times.
//  - Decode, from shadow:
//    - tens = v/10, ones = v%10; no operand exceeds 99 after the range check.
//    - Range check: a field outside its valid range shows dash (7'h40) on both of its digits.
//    - Hours 1..9: hh tens digit is blank (7'h00).
//    - Patterns (active-high) 0..9 = 3F 06 5B 4F 66 6D 7D 07 7F 6F.
//    - dp lit only on digit 4, and only when shadow pm = 1.
//  - Outputs are registered: the value at cycle t+1 is computed from cnt/dig/shadow at cycle t.
//    - an enables bit dig only when cnt >= BLANK; otherwise all anodes are disabled.
//    - seg/dp carry the pattern for dig whenever an is enabled, and are unlit otherwise.
//  - Frame period = 6*SCAN_DIV cycles. Digit slots run 0..5 in order and wrap 5->0.
//  - Input changes at any cycle other than a snapshot edge never alter the outputs.
//  - Reset asserted mid-frame: outputs go inactive immediately. After release, scanning
//    restarts at dig 0 with a fresh snapshot (frame_start pulses on the first clock).
// TESTING
//  1. Hold reset low, toggle clk and inputs -> an=6'h3F, seg=7'h7F, dp=1, frame_start=0 throughout.
//  2. SEG/AN_ACTIVE_LOW=0, SCAN_DIV=4, BLANK=1, hh=12 mm=34 ss=56 pm=1; release reset ->
//     - frame_start pulses one cycle after release.
//     - an sequence 01,02,04,08,10,20, each slot with one blank cycle.
//     - seg sequence 7D,6D,66,4F,5B,06; dp=1 only while an=10.
//  3. hh=6, mm=5, ss=9, pm=0 ->
//     - digit5 seg=00 with an enabled; digit4 seg=7D.
//     - digit3 seg=3F; digit2 seg=6D.
//     - dp never lit.
//  4. Tearing: hh=11 mm=59 ss=59, then during dig 2 change to 12:00:00 ->
//     - remaining digits still show 11:59:59.
//     - new value appears only after the next frame_start.
//  5. mm=60, hh=0 (ss=7) -> digits 2..5 all seg=40, digit0 seg=07, digit1 seg=3F.
//     - Repeat with hh=13 -> same result.
//  6. Assert reset asynchronously while dig=3, cnt=2 ->
//     - an/seg go inactive before the next clk edge.
//     - After release: restart at an=01 with a fresh snapshot, frame_start=1.

Source files
------------

// File: rtl/clock_display_scan.sv
// Multiplexed 6-digit 7-segment driver for a 12-hour HH:MM:SS clock.
// Snapshots the time once per scan frame, converts to BCD, blanks the leading hour zero and marks PM on dp.
module clock_display_scan #(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned BLANK          = 2,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] hh,
  input  logic [7:0] mm,
  input  logic [7:0] ss,
  input  logic       pm,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an,
  output logic       frame_start
);

  localparam logic [15:0] CNT_LAST = 16'(SCAN_DIV - 1);
  localparam logic [15:0] BLANK_C  = 16'(BLANK);

  logic [15:0] cnt;
  logic [2:0]  dig;
  logic [24:0] shadow;
  logic        load_pend;
  logic        last;
  logic        snap;

  logic [5:0]  an_r,  an_nx;
  logic [6:0]  seg_r, seg_nx;
  logic        dp_r,  dp_nx;

  logic [7:0]  sh_hh, sh_mm, sh_ss;
  logic        sh_pm;
  logic [7:0]  field;
  logic        valid;
  logic [3:0]  tens, ones;
  logic [6:0]  pat;
  logic        en;

  assign last = (cnt == CNT_LAST);
  // A new frame latches the time so no frame shows a mix of two clock states.
  assign snap = load_pend || (last && (dig == 3'd5));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      dig         <= '0;
      shadow      <= '0;
      load_pend   <= 1'b1;
      frame_start <= 1'b0;
      an_r        <= '0;
      seg_r       <= '0;
      dp_r        <= 1'b0;
    end else begin
      cnt <= last ? '0 : cnt + 16'd1;
      if (last) dig <= (dig == 3'd5) ? 3'd0 : dig + 3'd1;
      if (snap) shadow <= {hh, mm, ss, pm};
      load_pend   <= 1'b0;
      frame_start <= snap;
      an_r        <= an_nx;
      seg_r       <= seg_nx;
      dp_r        <= dp_nx;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'h3F;
      4'd1: seg7 = 7'h06;
      4'd2: seg7 = 7'h5B;
      4'd3: seg7 = 7'h4F;
      4'd4: seg7 = 7'h66;
      4'd5: seg7 = 7'h6D;
      4'd6: seg7 = 7'h7D;
      4'd7: seg7 = 7'h07;
      4'd8: seg7 = 7'h7F;
      4'd9: seg7 = 7'h6F;
      default: seg7 = 7'h40;
    endcase
  endfunction

  assign sh_hh = shadow[24:17];
  assign sh_mm = shadow[16:9];
  assign sh_ss = shadow[8:1];
  assign sh_pm = shadow[0];

  always_comb begin
    field  = '0;
    valid  = 1'b0;
    case (dig)
      3'd0, 3'd1: begin field = sh_ss; valid = (sh_ss < 8'd60); end
      3'd2, 3'd3: begin field = sh_mm; valid = (sh_mm < 8'd60); end
      default:    begin field = sh_hh; valid = (sh_hh >= 8'd1) && (sh_hh <= 8'd12); end
    endcase
    tens = 4'(field / 8'd10);
    ones = 4'(field % 8'd10);
    pat  = seg7(dig[0] ? tens : ones);
    if (!valid)                             pat = 7'h40;
    else if ((dig == 3'd5) && (tens == '0)) pat = '0;
    en     = (cnt >= BLANK_C);
    an_nx  = en ? (6'd1 << dig) : '0;
    seg_nx = en ? pat : '0;
    dp_nx  = en && (dig == 3'd4) && sh_pm;
  end

  assign an  = an_r  ^ {6{AN_ACTIVE_LOW}};
  assign seg = seg_r ^ {7{SEG_ACTIVE_LOW}};
  assign dp  = dp_r  ^ SEG_ACTIVE_LOW;

endmodule
